// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory controller.
// Instruction fetch (read-only) and data load/store share the port; reads
// are tracked over a fixed RD_LATENCY and answered to the issuing requester.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_req_valid_in,
  output logic                  if_req_ready_out,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_resp_valid_out,
  output logic [DATA_WIDTH-1:0] if_rd_data_out,
  input  logic                  d_req_valid_in,
  output logic                  d_req_ready_out,
  input  logic [ADDR_WIDTH-1:0] d_addr_in,
  input  logic [DATA_WIDTH-1:0] d_wr_data_in,
  input  logic                  d_we_in,
  output logic                  d_resp_valid_out,
  output logic [DATA_WIDTH-1:0] d_rd_data_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_wr_data_out,
  output logic                  mem_we_out,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_in,
  output logic                  busy_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [2:0]            lat_cnt_q, lat_cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  rd_id_q, rd_id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] if_rd_data_q, if_rd_data_d;
  logic [DATA_WIDTH-1:0] d_rd_data_q, d_rd_data_d;
  logic                  if_resp_valid_q, if_resp_valid_d;
  logic                  d_resp_valid_q, d_resp_valid_d;

  logic                  idle;
  logic                  gnt_if;
  logic                  gnt_d;

  // Round-robin grant: on conflict the requester not granted last time wins.
  // Reset gates the grants so readies and write enable stay low under reset.
  always_comb begin
    idle   = (state_q == ST_IDLE);
    gnt_if = idle && !rst_in && if_req_valid_in &&
             (!d_req_valid_in || (last_grant_q == GNT_D));
    gnt_d  = idle && !rst_in && d_req_valid_in &&
             (!if_req_valid_in || (last_grant_q == GNT_IF));
  end

  // Memory-side mux: granted requester in an accept cycle, latched read
  // address otherwise.
  always_comb begin
    if_req_ready_out = gnt_if;
    d_req_ready_out  = gnt_d;
    mem_addr_out     = addr_q;
    mem_wr_data_out  = '0;
    mem_we_out       = 1'b0;
    if (gnt_if) begin
      mem_addr_out = if_addr_in;
    end else if (gnt_d) begin
      mem_addr_out    = d_addr_in;
      mem_wr_data_out = d_wr_data_in;
      mem_we_out      = d_we_in;
    end
  end

  // Next-state logic: accept in IDLE, count read latency in BUSY.
  always_comb begin
    state_d         = state_q;
    lat_cnt_d       = lat_cnt_q;
    last_grant_d    = last_grant_q;
    rd_id_d         = rd_id_q;
    addr_d          = addr_q;
    if_rd_data_d    = if_rd_data_q;
    d_rd_data_d     = d_rd_data_q;
    if_resp_valid_d = 1'b0;
    d_resp_valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_if) begin
          last_grant_d = GNT_IF;
          addr_d       = if_addr_in;
          rd_id_d      = GNT_IF;
          lat_cnt_d    = 3'd1;
          state_d      = ST_BUSY;
        end else if (gnt_d) begin
          last_grant_d = GNT_D;
          if (!d_we_in) begin
            addr_d    = d_addr_in;
            rd_id_d   = GNT_D;
            lat_cnt_d = 3'd1;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (lat_cnt_q == 3'(RD_LATENCY)) begin
          if (rd_id_q == GNT_IF) begin
            if_rd_data_d    = mem_rd_data_in;
            if_resp_valid_d = 1'b1;
          end else begin
            d_rd_data_d    = mem_rd_data_in;
            d_resp_valid_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; an outstanding read is dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= ST_IDLE;
      lat_cnt_q       <= '0;
      last_grant_q    <= GNT_D;
      rd_id_q         <= GNT_IF;
      addr_q          <= '0;
      if_rd_data_q    <= '0;
      d_rd_data_q     <= '0;
      if_resp_valid_q <= 1'b0;
      d_resp_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      lat_cnt_q       <= lat_cnt_d;
      last_grant_q    <= last_grant_d;
      rd_id_q         <= rd_id_d;
      addr_q          <= addr_d;
      if_rd_data_q    <= if_rd_data_d;
      d_rd_data_q     <= d_rd_data_d;
      if_resp_valid_q <= if_resp_valid_d;
      d_resp_valid_q  <= d_resp_valid_d;
    end
  end

  assign if_resp_valid_out = if_resp_valid_q;
  assign if_rd_data_out    = if_rd_data_q;
  assign d_resp_valid_out  = d_resp_valid_q;
  assign d_rd_data_out     = d_rd_data_q;
  assign busy_out          = (state_q == ST_BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses RD_LATENCY=1, instance 1 uses
// RD_LATENCY=2. Read responses are checked by a scoreboard monitor.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  if_v, if_rdy, if_rv, d_v, d_rdy, d_we, d_rv, mem_we, busy;
  logic [31:0] if_a [2];
  logic [31:0] if_rd [2];
  logic [31:0] d_a [2];
  logic [31:0] d_wd [2];
  logic [31:0] d_rd [2];
  logic [31:0] mem_a [2];
  logic [31:0] mem_wd [2];
  logic [31:0] mem_rd [2];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  logic glog[$];
  bit   log_en = 1'b0;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) u_l1 (
    .clk_in(clk), .rst_in(rst),
    .if_req_valid_in(if_v[0]), .if_req_ready_out(if_rdy[0]), .if_addr_in(if_a[0]),
    .if_resp_valid_out(if_rv[0]), .if_rd_data_out(if_rd[0]),
    .d_req_valid_in(d_v[0]), .d_req_ready_out(d_rdy[0]), .d_addr_in(d_a[0]),
    .d_wr_data_in(d_wd[0]), .d_we_in(d_we[0]),
    .d_resp_valid_out(d_rv[0]), .d_rd_data_out(d_rd[0]),
    .mem_addr_out(mem_a[0]), .mem_wr_data_out(mem_wd[0]), .mem_we_out(mem_we[0]),
    .mem_rd_data_in(mem_rd[0]), .busy_out(busy[0])
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(2)) u_l2 (
    .clk_in(clk), .rst_in(rst),
    .if_req_valid_in(if_v[1]), .if_req_ready_out(if_rdy[1]), .if_addr_in(if_a[1]),
    .if_resp_valid_out(if_rv[1]), .if_rd_data_out(if_rd[1]),
    .d_req_valid_in(d_v[1]), .d_req_ready_out(d_rdy[1]), .d_addr_in(d_a[1]),
    .d_wr_data_in(d_wd[1]), .d_we_in(d_we[1]),
    .d_resp_valid_out(d_rv[1]), .d_rd_data_out(d_rd[1]),
    .mem_addr_out(mem_a[1]), .mem_wr_data_out(mem_wd[1]), .mem_we_out(mem_we[1]),
    .mem_rd_data_in(mem_rd[1]), .busy_out(busy[1])
  );

  // Memory contents as seen by the bench.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Memory controller model: data valid exactly RD_LATENCY cycles after the
  // read address is sampled, junk in every other cycle.
  logic [1:0]  p1_v, p2_v;
  logic [31:0] p1_a [2];
  logic [31:0] p2_a [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      p1_v[i] <= (if_v[i] & if_rdy[i]) | (d_v[i] & d_rdy[i] & ~d_we[i]);
      p1_a[i] <= mem_a[i];
      p2_v[i] <= p1_v[i];
      p2_a[i] <= p1_a[i];
    end
  end
  always_comb begin
    mem_rd[0] = p1_v[0] ? memf(p1_a[0]) : {16'hBAD0, cyc};
    mem_rd[1] = p2_v[1] ? memf(p2_a[1]) : {16'hBAD1, cyc};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic mon_pop(input int i, input logic id, input logic [31:0] data);
    exp_t e;
    bit   have;
    e = '0;
    have = 1'b0;
    if (i == 0) begin
      if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
    end else begin
      if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
    end
    if (!have) begin
      n_total++;
      $display("FAIL unexpected_resp: inst %0d got id %0d data %h expected no response", i, id, data);
    end else begin
      check($sformatf("resp_id_inst%0d", i), 64'(id), 64'(e.id));
      check($sformatf("resp_data_inst%0d", i), 64'(data), 64'(e.data));
    end
  endtask

  // Response monitor, busy/grant checker and grant logger.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (if_rv[i]) mon_pop(i, 1'b0, if_rd[i]);
      if (d_rv[i])  mon_pop(i, 1'b1, d_rd[i]);
      if (busy[i] === 1'b1)
        check($sformatf("no_grant_busy_inst%0d", i), 64'({if_rdy[i], d_rdy[i]}), 64'd0);
    end
    if (log_en && (if_rdy[0] || d_rdy[0])) glog.push_back(d_rdy[0]);
  end

  // Present one request and hold it until accepted; reads push their
  // expected response. Called just after a rising edge.
  task automatic issue(input int i, input bit is_d, input bit we,
                       input logic [31:0] a, input logic [31:0] wd);
    bit ok;
    ok = 1'b0;
    if (is_d) begin d_v[i] = 1'b1; d_a[i] = a; d_wd[i] = wd; d_we[i] = we; end
    else begin if_v[i] = 1'b1; if_a[i] = a; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_d ? d_rdy[i] : if_rdy[i]) begin
        ok = 1'b1;
        if (!we) begin
          if (i == 0) sb0.push_back({is_d, memf(a)});
          else        sb1.push_back({is_d, memf(a)});
        end
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (is_d) begin d_v[i] = 1'b0; d_we[i] = 1'b0; end
    else if_v[i] = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: inst %0d is_d %0d addr %h never got ready", i, is_d, a);
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    if_v = '0; d_v = '0; d_we = '0;
    for (int i = 0; i < 2; i++) begin
      if_a[i] = '0; d_a[i] = '0; d_wd[i] = '0;
    end
    @(posedge clk);
    #1;

    // Reset with both valids high, then IF/D contention with D reads.
    log_en = 1'b1;
    fork
      for (int k = 0; k < 4; k++) issue(0, 1'b0, 1'b0, 32'h100 + 32'(4 * k), '0);
      for (int k = 0; k < 4; k++) issue(0, 1'b1, 1'b0, 32'h200 + 32'(4 * k), '0);
      begin
        repeat (2) begin
          @(negedge clk);
          check("rst_readies", 64'({if_rdy[0], d_rdy[0]}), 64'd0);
          check("rst_mem_we", 64'(mem_we[0]), 64'd0);
          check("rst_resp_valid", 64'({if_rv[0], d_rv[0]}), 64'd0);
          check("rst_busy", 64'(busy[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_idle_if_ready", 64'({if_rdy[0], d_rdy[0]}), 64'b10);
      end
    join
    log_en = 1'b0;
    check("grant_count", 64'(glog.size()), 64'd8);
    for (int k = 0; k < 8 && k < glog.size(); k++)
      check($sformatf("grant_order_%0d", k), 64'(glog[k]), 64'(k % 2));
    settle();

    // Single fetch, RD_LATENCY=1.
    fork
      issue(0, 1'b0, 1'b0, 32'h40, '0);
      begin
        @(negedge clk);
        check("sf_c0_ready", 64'(if_rdy[0]), 64'd1);
        check("sf_c0_addr", 64'(mem_a[0]), 64'h40);
        check("sf_c0_we", 64'(mem_we[0]), 64'd0);
        @(negedge clk);
        check("sf_c1_busy", 64'(busy[0]), 64'd1);
        check("sf_c1_addr", 64'(mem_a[0]), 64'h40);
        check("sf_c1_rv", 64'(if_rv[0]), 64'd0);
        @(negedge clk);
        check("sf_c2_rv", 64'(if_rv[0]), 64'd1);
        check("sf_c2_data", 64'(if_rd[0]), 64'hDEADBEEF);
        check("sf_c2_d_rv", 64'(d_rv[0]), 64'd0);
        check("sf_c2_busy", 64'(busy[0]), 64'd0);
      end
    join
    settle();

    // Back-to-back D writes.
    fork
      for (int k = 0; k < 3; k++)
        issue(0, 1'b1, 1'b1, 32'h1100 + 32'(4 * k), 32'h1111_0000 + 32'(k));
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check($sformatf("wr_we_%0d", k), 64'(mem_we[0]), 64'd1);
          check($sformatf("wr_addr_%0d", k), 64'(mem_a[0]), 64'(32'h1100 + 32'(4 * k)));
          check($sformatf("wr_data_%0d", k), 64'(mem_wd[0]), 64'(32'h1111_0000 + 32'(k)));
        end
        @(negedge clk);
        check("wr_we_after", 64'(mem_we[0]), 64'd0);
        check("wr_busy_after", 64'(busy[0]), 64'd0);
      end
    join
    settle();

    // RD_LATENCY=2: D read, IF request arriving one cycle later.
    fork
      issue(1, 1'b1, 1'b0, 32'h300, '0);
      begin
        @(posedge clk);
        #1;
        issue(1, 1'b0, 1'b0, 32'h400, '0);
      end
      begin
        @(negedge clk);
        check("l2_c0_d_ready", 64'(d_rdy[1]), 64'd1);
        check("l2_c0_addr", 64'(mem_a[1]), 64'h300);
        @(negedge clk);
        check("l2_c1_busy", 64'(busy[1]), 64'd1);
        check("l2_c1_addr", 64'(mem_a[1]), 64'h300);
        check("l2_c1_if_ready", 64'(if_rdy[1]), 64'd0);
        @(negedge clk);
        check("l2_c2_addr", 64'(mem_a[1]), 64'h300);
        check("l2_c2_if_ready", 64'(if_rdy[1]), 64'd0);
        check("l2_c2_d_rv", 64'(d_rv[1]), 64'd0);
        @(negedge clk);
        check("l2_c3_d_rv", 64'(d_rv[1]), 64'd1);
        check("l2_c3_d_data", 64'(d_rd[1]), 64'(memf(32'h300)));
        check("l2_c3_if_ready", 64'(if_rdy[1]), 64'd1);
        check("l2_c3_addr", 64'(mem_a[1]), 64'h400);
      end
    join
    settle();

    // Reset while a read is outstanding: that read is dropped.
    issue(0, 1'b0, 1'b0, 32'h80, '0);
    rst = 1'b1;
    sb0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rmr_busy", 64'(busy[0]), 64'd0);
    check("rmr_rv", 64'({if_rv[0], d_rv[0]}), 64'd0);
    settle();
    issue(0, 1'b0, 1'b0, 32'h84, '0);
    settle();

    // Drain: every expected response must have arrived.
    for (int k = 0; k < 20 && (sb0.size() + sb1.size()) != 0; k++) @(posedge clk);
    check("sb0_empty", 64'(sb0.size()), 64'd0);
    check("sb1_empty", 64'(sb1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
